// File: rtl/fsm_ctrl_nch.sv
// fsm_ctrl_nch: supervisory controller for NCH FIFO channels.
// Latches per-channel thresholds during INIT, tracks idle/active traffic,
// and records sticky per-channel errors with a saturating entry counter.
module fsm_ctrl_nch #(
    parameter int NCH      = 5,
    parameter int THW      = 4,
    parameter int IDLE_CNT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 err_clr,
    input  logic [NCH*THW-1:0]   umbrales_in,
    input  logic [NCH-1:0]       FIFO_error,
    input  logic [NCH-1:0]       FIFO_empty,
    output logic [NCH*THW-1:0]   umbrales_out,
    output logic                 idle_out,
    output logic                 active_out,
    output logic [NCH-1:0]       error_out,
    output logic [7:0]           err_count,
    output logic [2:0]           state_out
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    // Idle counter compares one step ahead so the IDLE transition lands on
    // the edge where the count would reach IDLE_CNT.
    localparam logic [8:0] IDLE_LIM = 9'(IDLE_CNT);

    state_t               r_state;
    logic [NCH*THW-1:0]   r_umb;
    logic                 r_idle;
    logic                 r_active;
    logic [NCH-1:0]       r_err;
    logic [7:0]           r_err_cnt;
    logic [7:0]           r_idle_cnt;

    logic                 w_any_err;
    logic                 w_all_empty;
    logic [8:0]           w_idle_inc;
    logic [7:0]           w_err_cnt_inc;

    assign w_any_err     = |FIFO_error;
    assign w_all_empty   = &FIFO_empty;
    assign w_idle_inc    = {1'b0, r_idle_cnt} + 9'd1;
    assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;

    // State register and all Moore outputs; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_RESET;
            r_umb      <= '0;
            r_idle     <= 1'b0;
            r_active   <= 1'b0;
            r_err      <= '0;
            r_err_cnt  <= 8'd0;
            r_idle_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state    <= S_INIT;
                    r_umb      <= '0;
                    r_idle     <= 1'b0;
                    r_active   <= 1'b0;
                    r_idle_cnt <= 8'd0;
                end

                S_INIT: begin
                    // Thresholds track the input on every INIT edge, including the exit edge.
                    r_umb      <= umbrales_in;
                    r_idle_cnt <= 8'd0;
                    if (w_any_err) begin
                        r_state   <= S_ERROR;
                        r_err     <= FIFO_error;
                        r_err_cnt <= w_err_cnt_inc;
                        r_idle    <= 1'b0;
                        r_active  <= 1'b0;
                    end else if (!init) begin
                        r_state  <= S_IDLE;
                        r_idle   <= 1'b1;
                        r_active <= 1'b0;
                    end
                end

                S_IDLE: begin
                    if (w_any_err) begin
                        r_state    <= S_ERROR;
                        r_err      <= FIFO_error;
                        r_err_cnt  <= w_err_cnt_inc;
                        r_idle     <= 1'b0;
                        r_active   <= 1'b0;
                        r_idle_cnt <= 8'd0;
                    end else if (init) begin
                        r_state  <= S_INIT;
                        r_idle   <= 1'b0;
                        r_active <= 1'b0;
                    end else if (!w_all_empty) begin
                        r_state    <= S_ACTIVE;
                        r_idle     <= 1'b0;
                        r_active   <= 1'b1;
                        r_idle_cnt <= 8'd0;
                    end
                end

                S_ACTIVE: begin
                    if (w_any_err) begin
                        r_state    <= S_ERROR;
                        r_err      <= FIFO_error;
                        r_err_cnt  <= w_err_cnt_inc;
                        r_idle     <= 1'b0;
                        r_active   <= 1'b0;
                        r_idle_cnt <= 8'd0;
                    end else if (init) begin
                        r_state    <= S_INIT;
                        r_idle     <= 1'b0;
                        r_active   <= 1'b0;
                        r_idle_cnt <= 8'd0;
                    end else if (w_all_empty) begin
                        if (w_idle_inc == IDLE_LIM) begin
                            r_state    <= S_IDLE;
                            r_idle     <= 1'b1;
                            r_active   <= 1'b0;
                            r_idle_cnt <= 8'd0;
                        end else begin
                            r_idle_cnt <= w_idle_inc[7:0];
                        end
                    end else begin
                        // Any traffic restarts the quiet-period count.
                        r_idle_cnt <= 8'd0;
                    end
                end

                S_ERROR: begin
                    // Errors accumulate; init is deliberately ignored here.
                    if (err_clr && !w_any_err) begin
                        r_state <= S_INIT;
                        r_err   <= '0;
                    end else begin
                        r_err <= r_err | FIFO_error;
                    end
                    r_idle     <= 1'b0;
                    r_active   <= 1'b0;
                    r_idle_cnt <= 8'd0;
                end

                default: begin
                    r_state    <= S_RESET;
                    r_idle     <= 1'b0;
                    r_active   <= 1'b0;
                    r_idle_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign umbrales_out = r_umb;
    assign idle_out     = r_idle;
    assign active_out   = r_active;
    assign error_out    = r_err;
    assign err_count    = r_err_cnt;
    assign state_out    = r_state;

endmodule

// File: tb/tb_fsm_ctrl_nch.sv
// tb_fsm_ctrl_nch: directed vectors with a queue-based scoreboard.
// The stimulus pushes the hand-computed expected outputs for each clock;
// an independent monitor pops and compares one entry per cycle.
module tb_fsm_ctrl_nch;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        err_clr;
    logic [19:0] umbrales_in;
    logic [4:0]  FIFO_error;
    logic [4:0]  FIFO_empty;
    logic [19:0] umbrales_out;
    logic        idle_out;
    logic        active_out;
    logic [4:0]  error_out;
    logic [7:0]  err_count;
    logic [2:0]  state_out;

    typedef struct {
        bit          chk;
        logic [2:0]  st;
        logic [4:0]  eo;
        logic [7:0]  cnt;
        logic [19:0] umb;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    fsm_ctrl_nch #(.NCH(5), .THW(4), .IDLE_CNT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .err_clr      (err_clr),
        .umbrales_in  (umbrales_in),
        .FIFO_error   (FIFO_error),
        .FIFO_empty   (FIFO_empty),
        .umbrales_out (umbrales_out),
        .idle_out     (idle_out),
        .active_out   (active_out),
        .error_out    (error_out),
        .err_count    (err_count),
        .state_out    (state_out)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input string nm, input logic rn, input logic in, input logic cl,
                       input logic [19:0] ui, input logic [4:0] fe, input logic [4:0] fm,
                       input bit chk, input logic [2:0] es, input logic [4:0] eeo,
                       input logic [7:0] ecnt, input logic [19:0] eumb);
        exp_t e;
        reset       = rn;
        init        = in;
        err_clr     = cl;
        umbrales_in = ui;
        FIFO_error  = fe;
        FIFO_empty  = fm;
        e.chk = chk;
        e.st  = es;
        e.eo  = eeo;
        e.cnt = ecnt;
        e.umb = eumb;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per clock, compared on the falling edge.
    initial begin
        exp_t  e;
        string nm;
        logic  eidle, eact;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.chk) begin
                    eidle = (e.st == 3'd2);
                    eact  = (e.st == 3'd3);
                    n_vec++;
                    if (state_out !== e.st || idle_out !== eidle || active_out !== eact ||
                        error_out !== e.eo || err_count !== e.cnt || umbrales_out !== e.umb) begin
                        n_fail++;
                        $display("FAIL %s: got st=%0d idle=%b act=%b err=%b cnt=%0d umb=%h, want st=%0d idle=%b act=%b err=%b cnt=%0d umb=%h",
                                 nm, state_out, idle_out, active_out, error_out, err_count, umbrales_out,
                                 e.st, eidle, eact, e.eo, e.cnt, e.umb);
                    end
                end
            end
        end
    end

    localparam logic [19:0] U1 = 20'hA5C3F;
    localparam logic [19:0] U2 = 20'h12345;

    initial begin
        int waited;
        //   name           rst in clr umb_in fe     fm     chk st  eo     cnt umb
        cyc("rst0",          0, 1, 0, U1, 5'h00, 5'h1F, 1, 0, 5'h00, 0, 20'h0);
        cyc("rst1",          0, 1, 0, U1, 5'h00, 5'h1F, 1, 0, 5'h00, 0, 20'h0);
        cyc("rst_release",   1, 1, 0, U1, 5'h00, 5'h1F, 1, 1, 5'h00, 0, 20'h0);
        cyc("init_load",     1, 1, 0, U1, 5'h00, 5'h1F, 1, 1, 5'h00, 0, U1);
        cyc("init_to_idle",  1, 0, 0, U1, 5'h00, 5'h1F, 1, 2, 5'h00, 0, U1);
        cyc("idle_umb_hold", 1, 0, 0, U2, 5'h00, 5'h1F, 1, 2, 5'h00, 0, U1);
        cyc("idle_to_act",   1, 0, 0, U2, 5'h00, 5'h1B, 1, 3, 5'h00, 0, U1);
        cyc("act_quiet1",    1, 0, 0, U2, 5'h00, 5'h1F, 1, 3, 5'h00, 0, U1);
        cyc("act_restart",   1, 0, 0, U2, 5'h00, 5'h1E, 1, 3, 5'h00, 0, U1);
        cyc("act_quiet1b",   1, 0, 0, U2, 5'h00, 5'h1F, 1, 3, 5'h00, 0, U1);
        cyc("act_to_idle",   1, 0, 0, U2, 5'h00, 5'h1F, 1, 2, 5'h00, 0, U1);
        cyc("idle_to_act2",  1, 0, 0, U2, 5'h00, 5'h1B, 1, 3, 5'h00, 0, U1);
        cyc("err_entry",     1, 0, 0, U2, 5'h04, 5'h1B, 1, 4, 5'h04, 1, U1);
        cyc("err_accum",     1, 0, 0, U2, 5'h10, 5'h1B, 1, 4, 5'h14, 1, U1);
        cyc("err_sticky",    1, 0, 0, U2, 5'h00, 5'h1F, 1, 4, 5'h14, 1, U1);
        cyc("err_init_ign",  1, 1, 0, U2, 5'h00, 5'h1F, 1, 4, 5'h14, 1, U1);
        cyc("clr_blocked",   1, 0, 1, U2, 5'h01, 5'h1F, 1, 4, 5'h15, 1, U1);
        cyc("clr_to_init",   1, 0, 1, U2, 5'h00, 5'h1F, 1, 1, 5'h00, 1, U1);
        cyc("init_err_pri",  1, 1, 0, U2, 5'h02, 5'h1F, 1, 4, 5'h02, 2, U2);
        cyc("clr_to_init2",  1, 0, 1, U2, 5'h00, 5'h1F, 1, 1, 5'h00, 2, U2);
        cyc("init_to_idle2", 1, 0, 0, U2, 5'h00, 5'h1F, 1, 2, 5'h00, 2, U2);
        cyc("idle_init_req", 1, 1, 0, U2, 5'h00, 5'h1F, 1, 1, 5'h00, 2, U2);
        cyc("init_to_idle3", 1, 0, 0, U2, 5'h00, 5'h1F, 1, 2, 5'h00, 2, U2);
        // 253 more ERROR entries bring the counter from 2 to 255.
        for (int i = 0; i < 253; i++) begin
            cyc("sat_err",   1, 0, 0, U2, 5'h01, 5'h1F, 0, 4, 5'h01, 8'(3 + i), U2);
            cyc("sat_clr",   1, 0, 1, U2, 5'h00, 5'h1F, 0, 1, 5'h00, 8'(3 + i), U2);
            cyc("sat_idle",  1, 0, 0, U2, 5'h00, 5'h1F, 0, 2, 5'h00, 8'(3 + i), U2);
        end
        cyc("cnt_at_255",    1, 0, 0, U2, 5'h00, 5'h1F, 1, 2, 5'h00, 255, U2);
        cyc("cnt_saturate",  1, 0, 0, U2, 5'h08, 5'h1F, 1, 4, 5'h08, 255, U2);
        cyc("clr_keeps_cnt", 1, 0, 1, U2, 5'h00, 5'h1F, 1, 1, 5'h00, 255, U2);
        cyc("back_to_idle",  1, 0, 0, U2, 5'h00, 5'h1F, 1, 2, 5'h00, 255, U2);
        cyc("pre_rst_act",   1, 0, 0, U2, 5'h00, 5'h0F, 1, 3, 5'h00, 255, U2);
        cyc("rst_mid_act",   0, 1, 1, U2, 5'h1F, 5'h0F, 1, 0, 5'h00, 0, 20'h0);
        cyc("rst_release2",  1, 1, 0, U2, 5'h00, 5'h1F, 1, 1, 5'h00, 0, 20'h0);
        cyc("init_reload",   1, 0, 0, U2, 5'h00, 5'h1F, 1, 2, 5'h00, 0, U2);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
